// File: rtl/core_ma_sb.sv
// core_ma_sb: memory-access stage (ex->wb) with posted store buffer, Avalon-MM master.
// Ports: em_* from ex (valid/ready), mw_* to wb (valid/ready), avl_* Avalon master, sb_empty.
module core_ma_sb #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              em_valid,
  output logic              em_ready,
  input  logic [31:0]       em_reg_data_mem_addr,
  input  logic [31:0]       em_csr_data_mem_data,
  input  logic              em_mem_read,
  input  logic              em_mem_write,
  input  logic [2:0]        em_mem_op_type,
  input  logic [4:0]        em_rd,
  input  logic              em_reg_write,
  input  logic [11:0]       em_csr,
  input  logic              em_csr_write,
  output logic              mw_valid,
  input  logic              mw_ready,
  output logic [31:0]       mw_reg_data,
  output logic [31:0]       mw_mem_data,
  output logic [31:0]       mw_csr_data,
  output logic [4:0]        mw_rd,
  output logic              mw_reg_write,
  output logic              mw_reg_write_sel,
  output logic [11:0]       mw_csr,
  output logic              mw_csr_write,
  output logic              mw_misalign,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] avl_address,
  output logic [3:0]        avl_byteenable,
  output logic              avl_read,
  output logic              avl_write,
  output logic [31:0]       avl_writedata,
  input  logic [31:0]       avl_readdata,
  input  logic              avl_readdatavalid,
  input  logic              avl_waitrequest
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LD_REQ,
    S_LD_WAIT
  } state_t;

  state_t r_state, w_state_nx;

  logic [29:0]   r_sb_addr [SB_DEPTH];
  logic [3:0]    r_sb_be   [SB_DEPTH];
  logic [31:0]   r_sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_sb_vld;
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_wr_hold;

  logic [31:0]   r_ld_addr, r_ld_csr_data;
  logic [2:0]    r_ld_op;
  logic [4:0]    r_ld_rd;
  logic          r_ld_rw, r_ld_csrw;
  logic [11:0]   r_ld_csr;

  logic          w_full, w_hit, w_mis, w_acc;
  logic          w_ld_start, w_push, w_direct;
  logic          w_pop, w_rd_acc, w_rd_done;
  logic [1:0]    w_lane;
  logic [3:0]    w_st_be;
  logic [31:0]   w_st_data, w_sh, w_fmt, w_addr32;

  assign w_full   = (r_cnt == CW'(SB_DEPTH));
  assign sb_empty = (r_cnt == '0);
  assign w_lane   = em_reg_data_mem_addr[1:0];

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (r_sb_vld[i] &&
          r_sb_addr[i] == em_reg_data_mem_addr[31:2])
        w_hit = 1'b1;
  end

  always_comb begin
    w_mis = 1'b0;
    if (em_mem_read || em_mem_write) begin
      if (em_mem_op_type[1:0] == 2'b01)
        w_mis = w_lane[0];
      else if (em_mem_op_type[1:0] == 2'b10)
        w_mis = |w_lane;
    end
  end

  assign em_ready = (r_state == S_IDLE)
                  & (!mw_valid | mw_ready)
                  & !(em_mem_write & w_full)
                  & !(em_mem_read & w_hit);

  assign w_acc      = em_valid & em_ready;
  assign w_ld_start = w_acc & em_mem_read & !w_mis;
  assign w_push     = w_acc & em_mem_write & !w_mis;
  assign w_direct   = w_acc & !w_ld_start;

  always_comb begin
    w_st_be   = 4'b1111;
    w_st_data = em_csr_data_mem_data;
    case (em_mem_op_type[1:0])
      2'b00: begin
        w_st_be   = 4'b0001 << w_lane;
        w_st_data = {4{em_csr_data_mem_data[7:0]}};
      end
      2'b01: begin
        w_st_be   = 4'b0011 << w_lane;
        w_st_data = {2{em_csr_data_mem_data[15:0]}};
      end
      default: ;
    endcase
  end

  // A write that has been raised stays up until accepted, even
  // after a load has moved the FSM out of IDLE.
  assign avl_write = r_wr_hold
                   | ((r_state == S_IDLE) & !sb_empty);
  assign avl_read  = (r_state == S_LD_REQ) & !r_wr_hold;
  assign w_pop     = avl_write & !avl_waitrequest;
  assign w_rd_acc  = avl_read & !avl_waitrequest;
  assign w_rd_done = (r_state == S_LD_WAIT) & avl_readdatavalid;

  assign w_addr32 = avl_write ? {r_sb_addr[r_rp], 2'b00}
                              : {r_ld_addr[31:2], 2'b00};
  assign avl_address    = w_addr32[ADDR_W-1:0];
  assign avl_byteenable = avl_write ? r_sb_be[r_rp] : 4'b1111;
  assign avl_writedata  = r_sb_data[r_rp];

  assign w_sh = avl_readdata >> {r_ld_addr[1:0], 3'b000};

  always_comb begin
    w_fmt = w_sh;
    case (r_ld_op)
      3'b000:  w_fmt = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_fmt = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_fmt = {24'b0, w_sh[7:0]};
      3'b101:  w_fmt = {16'b0, w_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (w_ld_start) w_state_nx = S_LD_REQ;
      S_LD_REQ:  if (w_rd_acc) w_state_nx = S_LD_WAIT;
      S_LD_WAIT: if (avl_readdatavalid) w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_sb_vld  <= '0;
      r_wr_hold <= 1'b0;
    end else begin
      r_wr_hold <= avl_write & avl_waitrequest;
      if (w_push) begin
        r_sb_addr[r_wp] <= em_reg_data_mem_addr[31:2];
        r_sb_be[r_wp]   <= w_st_be;
        r_sb_data[r_wp] <= w_st_data;
        r_sb_vld[r_wp]  <= 1'b1;
        r_wp            <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_sb_vld[r_rp] <= 1'b0;
        r_rp           <= r_rp + PW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      r_ld_addr     <= '0;
      r_ld_csr_data <= '0;
      r_ld_op       <= '0;
      r_ld_rd       <= '0;
      r_ld_rw       <= 1'b0;
      r_ld_csr      <= '0;
      r_ld_csrw     <= 1'b0;
    end else if (w_ld_start) begin
      r_ld_addr     <= em_reg_data_mem_addr;
      r_ld_csr_data <= em_csr_data_mem_data;
      r_ld_op       <= em_mem_op_type;
      r_ld_rd       <= em_rd;
      r_ld_rw       <= em_reg_write;
      r_ld_csr      <= em_csr;
      r_ld_csrw     <= em_csr_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      mw_valid         <= 1'b0;
      mw_reg_data      <= '0;
      mw_mem_data      <= '0;
      mw_csr_data      <= '0;
      mw_rd            <= '0;
      mw_reg_write     <= 1'b0;
      mw_reg_write_sel <= 1'b0;
      mw_csr           <= '0;
      mw_csr_write     <= 1'b0;
      mw_misalign      <= 1'b0;
    end else begin
      if (mw_valid && mw_ready) mw_valid <= 1'b0;
      if (w_direct) begin
        mw_valid         <= 1'b1;
        mw_reg_data      <= em_reg_data_mem_addr;
        mw_mem_data      <= '0;
        mw_csr_data      <= em_csr_data_mem_data;
        mw_rd            <= em_rd;
        mw_reg_write     <= em_reg_write & !w_mis;
        mw_reg_write_sel <= 1'b0;
        mw_csr           <= em_csr;
        mw_csr_write     <= em_csr_write;
        mw_misalign      <= w_mis;
      end else if (w_rd_done) begin
        mw_valid         <= 1'b1;
        mw_reg_data      <= r_ld_addr;
        mw_mem_data      <= w_fmt;
        mw_csr_data      <= r_ld_csr_data;
        mw_rd            <= r_ld_rd;
        mw_reg_write     <= r_ld_rw;
        mw_reg_write_sel <= 1'b1;
        mw_csr           <= r_ld_csr;
        mw_csr_write     <= r_ld_csrw;
        mw_misalign      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_ma_sb.sv
// tb_core_ma_sb: directed bench for core_ma_sb.
// Drives em/avl/mw_ready, checks outputs against hand-computed values.
module tb_core_ma_sb;

  logic        clk = 1'b0;
  logic        rest;
  logic        em_valid, em_ready;
  logic [31:0] em_reg_data_mem_addr, em_csr_data_mem_data;
  logic        em_mem_read, em_mem_write;
  logic [2:0]  em_mem_op_type;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;
  logic        mw_valid, mw_ready;
  logic [31:0] mw_reg_data, mw_mem_data, mw_csr_data;
  logic [4:0]  mw_rd;
  logic        mw_reg_write, mw_reg_write_sel;
  logic [11:0] mw_csr;
  logic        mw_csr_write, mw_misalign, sb_empty;
  logic [31:0] avl_address;
  logic [3:0]  avl_byteenable;
  logic        avl_read, avl_write;
  logic [31:0] avl_writedata, avl_readdata;
  logic        avl_readdatavalid, avl_waitrequest;

  int checks = 0;
  int errors = 0;

  core_ma_sb #(.SB_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rest(rest),
    .em_valid(em_valid), .em_ready(em_ready),
    .em_reg_data_mem_addr(em_reg_data_mem_addr),
    .em_csr_data_mem_data(em_csr_data_mem_data),
    .em_mem_read(em_mem_read), .em_mem_write(em_mem_write),
    .em_mem_op_type(em_mem_op_type), .em_rd(em_rd),
    .em_reg_write(em_reg_write), .em_csr(em_csr),
    .em_csr_write(em_csr_write),
    .mw_valid(mw_valid), .mw_ready(mw_ready),
    .mw_reg_data(mw_reg_data), .mw_mem_data(mw_mem_data),
    .mw_csr_data(mw_csr_data), .mw_rd(mw_rd),
    .mw_reg_write(mw_reg_write),
    .mw_reg_write_sel(mw_reg_write_sel),
    .mw_csr(mw_csr), .mw_csr_write(mw_csr_write),
    .mw_misalign(mw_misalign), .sb_empty(sb_empty),
    .avl_address(avl_address),
    .avl_byteenable(avl_byteenable),
    .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata),
    .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid),
    .avl_waitrequest(avl_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic em_clr();
    em_valid = 0; em_mem_read = 0; em_mem_write = 0;
    em_reg_write = 0; em_csr_write = 0;
    em_mem_op_type = 3'b010;
    em_reg_data_mem_addr = 0; em_csr_data_mem_data = 0;
    em_rd = 0; em_csr = 0;
  endtask

  task automatic em_ld(input [31:0] a, input [2:0] op,
                       input [4:0] rd);
    em_clr();
    em_valid = 1; em_mem_read = 1; em_reg_write = 1;
    em_reg_data_mem_addr = a; em_mem_op_type = op; em_rd = rd;
  endtask

  task automatic em_st(input [31:0] a, input [31:0] d,
                       input [2:0] op);
    em_clr();
    em_valid = 1; em_mem_write = 1;
    em_reg_data_mem_addr = a; em_csr_data_mem_data = d;
    em_mem_op_type = op;
  endtask

  // Runs one load with a single-cycle read response; lat counts
  // edges from acceptance to the cycle mw_valid should be visible.
  task automatic do_load(input [31:0] a, input [2:0] op,
                         input [31:0] rdata, output int lat,
                         output logic [31:0] raddr,
                         output logic ok);
    em_ld(a, op, 5'd7);
    #1;
    cyc();
    em_clr();
    lat = 1; ok = 0; raddr = 0;
    for (int i = 0; i < 20; i++) begin
      if (avl_read && !avl_waitrequest) begin
        raddr = avl_address; ok = 1; break;
      end
      cyc(); lat++;
    end
    if (ok) begin
      cyc(); lat++;
      avl_readdatavalid = 1; avl_readdata = rdata;
      cyc(); lat++;
      avl_readdatavalid = 0;
    end
  endtask

  task automatic test_reset();
    rest = 1; em_clr(); mw_ready = 1;
    avl_waitrequest = 0; avl_readdatavalid = 0; avl_readdata = 0;
    cyc(); cyc();
    rest = 0; #1;
    checks++; if (mw_valid !== 1'b0) begin errors++; $display("FAIL rst_mw_valid got %b exp 0", mw_valid); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL rst_sb_empty got %b exp 1", sb_empty); end
    checks++; if ({avl_read, avl_write} !== 2'b00) begin errors++; $display("FAIL rst_avl got %b exp 00", {avl_read, avl_write}); end
    checks++; if (em_ready !== 1'b1) begin errors++; $display("FAIL rst_em_ready got %b exp 1", em_ready); end
    checks++; if (mw_reg_data !== 32'h0) begin errors++; $display("FAIL rst_reg_data got %h exp 0", mw_reg_data); end
  endtask

  task automatic test_alu();
    em_clr(); em_valid = 1; em_reg_write = 1; em_rd = 5;
    em_reg_data_mem_addr = 32'h1234_5678;
    em_csr_data_mem_data = 32'h0000_CAFE;
    em_csr = 12'h300; em_csr_write = 1; em_mem_op_type = 3'b000;
    #1;
    checks++; if (em_ready !== 1'b1) begin errors++; $display("FAIL alu_em_ready got %b exp 1", em_ready); end
    cyc(); em_clr(); #1;
    checks++; if (mw_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b exp 1", mw_valid); end
    checks++; if (mw_reg_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_reg_data got %h exp 12345678", mw_reg_data); end
    checks++; if (mw_csr_data !== 32'h0000_CAFE) begin errors++; $display("FAIL alu_csr_data got %h exp 0000cafe", mw_csr_data); end
    checks++; if ({mw_rd, mw_reg_write, mw_reg_write_sel, mw_misalign} !== {5'd5, 3'b100}) begin errors++; $display("FAIL alu_ctl got %h exp %h", {mw_rd, mw_reg_write, mw_reg_write_sel, mw_misalign}, {5'd5, 3'b100}); end
    checks++; if ({mw_csr, mw_csr_write} !== {12'h300, 1'b1}) begin errors++; $display("FAIL alu_csr got %h exp %h", {mw_csr, mw_csr_write}, {12'h300, 1'b1}); end
    checks++; if ({avl_read, avl_write} !== 2'b00) begin errors++; $display("FAIL alu_avl got %b exp 00", {avl_read, avl_write}); end
    cyc();
    checks++; if (mw_valid !== 1'b0) begin errors++; $display("FAIL alu_drop got %b exp 0", mw_valid); end
  endtask

  task automatic test_back_to_back();
    mw_ready = 0;
    em_clr(); em_valid = 1; em_reg_data_mem_addr = 32'hA;
    cyc();
    em_reg_data_mem_addr = 32'hB; #1;
    checks++; if (em_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", em_ready); end
    cyc();
    checks++; if ({mw_valid, mw_reg_data} !== {1'b1, 32'hA}) begin errors++; $display("FAIL b2b_hold got %h exp 1_0000000a", {mw_valid, mw_reg_data}); end
    mw_ready = 1; #1;
    checks++; if (em_ready !== 1'b1) begin errors++; $display("FAIL b2b_go got %b exp 1", em_ready); end
    cyc();
    checks++; if (mw_reg_data !== 32'hB) begin errors++; $display("FAIL b2b_B got %h exp b", mw_reg_data); end
    em_reg_data_mem_addr = 32'hC;
    cyc();
    checks++; if ({mw_valid, mw_reg_data} !== {1'b1, 32'hC}) begin errors++; $display("FAIL b2b_C got %h exp 1_0000000c", {mw_valid, mw_reg_data}); end
    em_clr(); cyc();
  endtask

  task automatic test_sb_wait();
    int n;
    avl_waitrequest = 1;
    em_st(32'h103, 32'hA5, 3'b000); #1;
    cyc(); em_clr();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) avl_waitrequest = 0;
      #1;
      if (!avl_write) break;
      if (i == 0) begin
        checks++; if (avl_address !== 32'h100) begin errors++; $display("FAIL sb_addr got %h exp 00000100", avl_address); end
        checks++; if (avl_byteenable !== 4'b1000) begin errors++; $display("FAIL sb_be got %b exp 1000", avl_byteenable); end
        checks++; if (avl_writedata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", avl_writedata); end
        checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL sb_nempty got %b exp 0", sb_empty); end
      end
      n++;
      cyc();
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL sb_hold_cycles got %0d exp 3", n); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL sb_empty_after got %b exp 1", sb_empty); end
  endtask

  task automatic test_load();
    int lat; logic [31:0] ra; logic ok;
    avl_waitrequest = 0; mw_ready = 1;
    do_load(32'h102, 3'b000, 32'h0080_0000, lat, ra, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lb_issue got %b exp 1", ok); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", lat); end
    checks++; if (ra !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", ra); end
    checks++; if ({mw_valid, mw_reg_write_sel, mw_reg_write} !== 3'b111) begin errors++; $display("FAIL lb_ctl got %b exp 111", {mw_valid, mw_reg_write_sel, mw_reg_write}); end
    checks++; if (mw_mem_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", mw_mem_data); end
    checks++; if (mw_reg_data !== 32'h102) begin errors++; $display("FAIL lb_reg_data got %h exp 00000102", mw_reg_data); end
    do_load(32'h102, 3'b100, 32'h0080_0000, lat, ra, ok);
    checks++; if ({ok, mw_valid, mw_mem_data} !== {2'b11, 32'h80}) begin errors++; $display("FAIL lbu_data got %h exp 3_00000080", {ok, mw_valid, mw_mem_data}); end
    do_load(32'h102, 3'b101, 32'hBEEF_1234, lat, ra, ok);
    checks++; if ({ok, mw_valid, mw_mem_data} !== {2'b11, 32'hBEEF}) begin errors++; $display("FAIL lhu_data got %h exp 3_0000beef", {ok, mw_valid, mw_mem_data}); end
    do_load(32'h202, 3'b001, 32'h8001_7FFF, lat, ra, ok);
    checks++; if ({ok, mw_valid, mw_mem_data} !== {2'b11, 32'hFFFF_8001}) begin errors++; $display("FAIL lh_data got %h exp 3_ffff8001", {ok, mw_valid, mw_mem_data}); end
    cyc();
  endtask

  task automatic test_misalign();
    avl_waitrequest = 0; mw_ready = 1;
    em_ld(32'h102, 3'b010, 5'd9); #1;
    checks++; if (em_ready !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", em_ready); end
    cyc(); em_clr(); #1;
    checks++; if ({mw_valid, mw_misalign, mw_reg_write} !== 3'b110) begin errors++; $display("FAIL mis_lw_ctl got %b exp 110", {mw_valid, mw_misalign, mw_reg_write}); end
    checks++; if (avl_read !== 1'b0) begin errors++; $display("FAIL mis_lw_read got %b exp 0", avl_read); end
    cyc();
    checks++; if ({mw_valid, avl_read} !== 2'b00) begin errors++; $display("FAIL mis_lw_after got %b exp 00", {mw_valid, avl_read}); end
    em_st(32'h101, 32'h1234, 3'b001);
    cyc(); em_clr(); #1;
    checks++; if ({mw_misalign, sb_empty, avl_write} !== 3'b110) begin errors++; $display("FAIL mis_sh got %b exp 110", {mw_misalign, sb_empty, avl_write}); end
    em_st(32'h102, 32'h1234, 3'b001);
    cyc(); em_clr(); #1;
    checks++; if ({avl_write, avl_byteenable, avl_writedata} !== {1'b1, 4'b1100, 32'h1234_1234}) begin errors++; $display("FAIL sh_lane2 got %h exp %h", {avl_write, avl_byteenable, avl_writedata}, {1'b1, 4'b1100, 32'h1234_1234}); end
    cyc(); cyc();
  endtask

  task automatic test_fill();
    logic [31:0] ad [4];
    logic [31:0] dt [4];
    int k;
    avl_waitrequest = 1; mw_ready = 1;
    for (int j = 0; j < 4; j++) begin
      em_st(32'h10 + 32'(4 * j), 32'(j + 1), 3'b010); #1;
      checks++; if (em_ready !== 1'b1) begin errors++; $display("FAIL fill_acc%0d got %b exp 1", j, em_ready); end
      cyc();
    end
    em_st(32'h20, 32'h5, 3'b010); #1;
    checks++; if (em_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", em_ready); end
    em_clr(); avl_waitrequest = 0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (avl_write) begin
        if (k < 4) begin ad[k] = avl_address; dt[k] = avl_writedata; end
        k++;
      end
      cyc();
    end
    checks++; if (k !== 4) begin errors++; $display("FAIL fill_count got %0d exp 4", k); end
    for (int j = 0; j < 4 && j < k; j++) begin
      checks++; if ({ad[j], dt[j]} !== {32'h10 + 32'(4 * j), 32'(j + 1)}) begin errors++; $display("FAIL fill_order%0d got %h exp %h", j, {ad[j], dt[j]}, {32'h10 + 32'(4 * j), 32'(j + 1)}); end
    end
    em_mem_write = 1; #1;
    checks++; if ({sb_empty, em_ready} !== 2'b11) begin errors++; $display("FAIL fill_drained got %b exp 11", {sb_empty, em_ready}); end
    em_clr();
  endtask

  task automatic test_hit();
    avl_waitrequest = 1; mw_ready = 1;
    em_st(32'h200, 32'h11, 3'b010); #1;
    cyc();
    em_st(32'h204, 32'h22, 3'b010);
    cyc();
    em_ld(32'h200, 3'b010, 5'd4); #1;
    checks++; if (em_ready !== 1'b0) begin errors++; $display("FAIL hit_block got %b exp 0", em_ready); end
    cyc();
    checks++; if (em_ready !== 1'b0) begin errors++; $display("FAIL hit_block2 got %b exp 0", em_ready); end
    em_reg_data_mem_addr = 32'h300; #1;
    checks++; if (em_ready !== 1'b1) begin errors++; $display("FAIL nohit_acc got %b exp 1", em_ready); end
    cyc(); em_clr(); #1;
    checks++; if ({avl_read, avl_write, avl_address} !== {2'b01, 32'h200}) begin errors++; $display("FAIL hit_wr_first got %h exp 1_00000200", {avl_read, avl_write, avl_address}); end
    avl_waitrequest = 0;
    cyc();
    checks++; if ({avl_read, avl_write, avl_address} !== {2'b10, 32'h300}) begin errors++; $display("FAIL hit_rd_issue got %h exp 2_00000300", {avl_read, avl_write, avl_address}); end
    checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL hit_rd_before_drain got %b exp 0", sb_empty); end
    cyc();
    checks++; if ({avl_read, avl_write} !== 2'b00) begin errors++; $display("FAIL hit_ldwait_bus got %b exp 00", {avl_read, avl_write}); end
    avl_readdatavalid = 1; avl_readdata = 32'hDEAD_BEEF;
    cyc(); avl_readdatavalid = 0; #1;
    checks++; if ({mw_valid, mw_mem_data} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL hit_ld_data got %h exp 1_deadbeef", {mw_valid, mw_mem_data}); end
    checks++; if ({avl_write, avl_address, avl_writedata} !== {1'b1, 32'h204, 32'h22}) begin errors++; $display("FAIL hit_drain2 got %h exp %h", {avl_write, avl_address, avl_writedata}, {1'b1, 32'h204, 32'h22}); end
    cyc();
    em_ld(32'h200, 3'b010, 5'd4); em_valid = 0; #1;
    checks++; if ({sb_empty, em_ready} !== 2'b11) begin errors++; $display("FAIL hit_release got %b exp 11", {sb_empty, em_ready}); end
    em_clr();
  endtask

  task automatic test_reset_ldwait();
    avl_waitrequest = 1; mw_ready = 1;
    em_st(32'h500, 32'h55, 3'b010);
    cyc(); em_clr(); #1;
    checks++; if (avl_write !== 1'b1) begin errors++; $display("FAIL rst_st_pending got %b exp 1", avl_write); end
    rest = 1; cyc(); rest = 0; #1;
    checks++; if ({sb_empty, avl_write} !== 2'b10) begin errors++; $display("FAIL rst_sb_discard got %b exp 10", {sb_empty, avl_write}); end
    avl_waitrequest = 0;
    em_ld(32'h400, 3'b010, 5'd3);
    cyc(); em_clr(); #1;
    checks++; if ({avl_read, avl_address} !== {1'b1, 32'h400}) begin errors++; $display("FAIL rst_ld_req got %h exp 1_00000400", {avl_read, avl_address}); end
    cyc();
    checks++; if (avl_read !== 1'b0) begin errors++; $display("FAIL rst_ld_wait got %b exp 0", avl_read); end
    rest = 1; cyc(); rest = 0; #1;
    checks++; if ({mw_valid, mw_reg_data, mw_mem_data, mw_rd} !== '0) begin errors++; $display("FAIL rst_mw_zero got %h exp 0", {mw_valid, mw_reg_data, mw_mem_data, mw_rd}); end
    checks++; if ({avl_read, avl_write, em_ready} !== 3'b001) begin errors++; $display("FAIL rst_ld_bus got %b exp 001", {avl_read, avl_write, em_ready}); end
    avl_readdatavalid = 1; avl_readdata = 32'h1234;
    cyc(); avl_readdatavalid = 0;
    cyc();
    checks++; if (mw_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rdv got %b exp 0", mw_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_sb_wait();
    test_load();
    test_misalign();
    test_fill();
    test_hit();
    test_reset_ldwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
